// File: rtl/isqrt_seq_ctrl_if.sv
// Handshake/result bundle between the lab front-end and the square-root controller.
// The front-end (master) issues start/x; the controller (slave) returns busy/done/root/rem.
interface isqrt_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  localparam int N = WIDTH / 2;

  logic             start;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             done;
  logic [N-1:0]     root;
  logic [N:0]       rem;

  modport master (
    output start,
    output x,
    input  busy,
    input  done,
    input  root,
    input  rem
  );

  modport slave (
    input  start,
    input  x,
    output busy,
    output done,
    output root,
    output rem
  );
endinterface

// File: rtl/isqrt_seq_ctrl.sv
// Sequential unsigned integer square root controller (restoring digit-by-digit).
// One radicand bit-pair is consumed per CALC cycle through a single shared
// N+3-bit trial subtractor; the result bit comes from its carry/overflow/sign flags.
module isqrt_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  isqrt_seq_ctrl_if.slave     bus
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r;
  logic [WIDTH-1:0] xs_r;
  logic [N-1:0]   pr_r;
  logic [N:0]     prem_r;
  logic [CW-1:0]  cnt_r;
  logic           busy_r;
  logic           done_r;
  logic [N-1:0]   root_r;
  logic [N:0]     rem_r;

  logic [N+2:0]   t_s;
  logic [N+2:0]   trial_s;
  logic [N+3:0]   sum_s;
  logic [N+2:0]   diff_s;
  logic           c_s;
  logic           sign_s;
  logic           ov_s;
  logic           ge_s;
  logic [N-1:0]   pr_nxt_s;
  logic [N:0]     prem_nxt_s;
  logic           unused_bits_s;

  // Trial subtract of {pr,01} from the current partial remainder plus next bit-pair.
  always_comb begin
    t_s     = {prem_r, xs_r[WIDTH-1 -: 2]};
    trial_s = {1'b0, pr_r, 2'b01};
    sum_s   = {1'b0, t_s} + {1'b0, ~trial_s} + {{(N+3){1'b0}}, 1'b1};
    c_s     = sum_s[N+3];
    diff_s  = sum_s[N+2:0];
    sign_s  = diff_s[N+2];
    // Subtraction overflows when operand signs differ and the result sign leaves the minuend's.
    ov_s    = (t_s[N+2] ^ trial_s[N+2]) & (diff_s[N+2] ^ t_s[N+2]);
    if (ov_s) begin
      ge_s = ~sign_s;
    end else begin
      ge_s = c_s;
    end
    if (ge_s) begin
      prem_nxt_s = diff_s[N:0];
      pr_nxt_s   = {pr_r[N-2:0], 1'b1};
    end else begin
      prem_nxt_s = t_s[N:0];
      pr_nxt_s   = {pr_r[N-2:0], 1'b0};
    end
  end

  // The dropped upper bits are provably zero whenever they would be kept.
  assign unused_bits_s = ^{diff_s[N+1], t_s[N+1]};

  // Control FSM with registered outputs; accepts in IDLE or DONE, iterates N times in CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      xs_r    <= {WIDTH{1'b0}};
      pr_r    <= {N{1'b0}};
      prem_r  <= {(N+1){1'b0}};
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      root_r  <= {N{1'b0}};
      rem_r   <= {(N+1){1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            xs_r    <= bus.x;
            pr_r    <= {N{1'b0}};
            prem_r  <= {(N+1){1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          pr_r   <= pr_nxt_s;
          prem_r <= prem_nxt_s;
          xs_r   <= {xs_r[WIDTH-3:0], 2'b00};
          if (cnt_r == CW'(N - 1)) begin
            // Final iteration: publish the result and return the counter to zero.
            cnt_r   <= {CW{1'b0}};
            root_r  <= pr_nxt_s;
            rem_r   <= prem_nxt_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= CALC;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.root = root_r;
  assign bus.rem  = rem_r;

endmodule
